// File: rtl/instruction_encoder_if.sv
// rtl/instruction_encoder_if.sv - command, response and SPI byte-master signal bundle for instruction_encoder
interface instruction_encoder_if #(
    parameter int INSTRUCTION_WIDTH = 8,
    parameter int ADDRESS_WIDTH     = 24,
    parameter int VALUE_WIDTH       = 32
);
    logic                         cmd_valid_i;
    logic                         cmd_ready_o;
    logic [INSTRUCTION_WIDTH-1:0] cmd_instruction_i;
    logic [ADDRESS_WIDTH-1:0]     cmd_address_i;
    logic [VALUE_WIDTH-1:0]       cmd_value_i;
    logic [7:0]                   spi_tx_byte_o;
    logic                         spi_tx_valid_o;
    logic                         spi_tx_ready_i;
    logic                         spi_rx_valid_i;
    logic [7:0]                   spi_rx_byte_i;
    logic                         resp_valid_o;
    logic [VALUE_WIDTH-1:0]       resp_data_o;
    logic                         busy_o;
    logic                         err_o;

    modport slave (
        input  cmd_valid_i, cmd_instruction_i, cmd_address_i, cmd_value_i,
        input  spi_tx_ready_i, spi_rx_valid_i, spi_rx_byte_i,
        output cmd_ready_o, spi_tx_byte_o, spi_tx_valid_o,
        output resp_valid_o, resp_data_o, busy_o, err_o
    );

    modport master (
        output cmd_valid_i, cmd_instruction_i, cmd_address_i, cmd_value_i,
        output spi_tx_ready_i, spi_rx_valid_i, spi_rx_byte_i,
        input  cmd_ready_o, spi_tx_byte_o, spi_tx_valid_o,
        input  resp_valid_o, resp_data_o, busy_o, err_o
    );
endinterface

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - serialises one host command into the SPI instruction-handler byte frame
module instruction_encoder #(
    parameter int         INSTRUCTION_WIDTH = 8,
    parameter int         ADDRESS_WIDTH     = 24,
    parameter int         VALUE_WIDTH       = 32,
    parameter logic [7:0] DUMMY_BYTE        = 8'h00
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    instruction_encoder_if.slave bus
);
    localparam logic [7:0] OP_WRITE              = 8'h01;
    localparam logic [7:0] OP_READ               = 8'h02;
    localparam logic [7:0] OP_BIND_INTERRUPT     = 8'h03;
    localparam logic [7:0] OP_BIND_READ_ADDRESS  = 8'h04;
    localparam logic [7:0] OP_BIND_WRITE_ADDRESS = 8'h05;
    localparam logic [7:0] OP_STREAM             = 8'h06;
    localparam logic [7:0] OP_TRANSFER           = 8'h07;
    localparam logic [7:0] OP_REPEAT             = 8'h08;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t                       state_q, state_d;
    logic [INSTRUCTION_WIDTH-1:0] op_q;
    logic [ADDRESS_WIDTH-1:0]     addr_q;
    logic [VALUE_WIDTH-1:0]       val_q;
    logic [3:0]                   len_q;
    logic [3:0]                   idx_q;
    logic [VALUE_WIDTH-1:0]       shift_q, shift_d;
    logic [VALUE_WIDTH-1:0]       resp_q;
    logic [63:0]                  frame;
    logic [63:0]                  frame_shifted;
    logic                         accept;
    logic                         capture;
    logic                         last_byte;

    // Zero length marks an opcode the handler does not understand.
    function automatic logic [3:0] frame_len(input logic [INSTRUCTION_WIDTH-1:0] op);
        case (op)
            OP_WRITE:                         frame_len = 4'd8;
            OP_READ, OP_BIND_INTERRUPT,
            OP_BIND_READ_ADDRESS,
            OP_BIND_WRITE_ADDRESS:            frame_len = 4'd4;
            OP_STREAM:                        frame_len = 4'd5;
            OP_TRANSFER:                      frame_len = 4'd2;
            OP_REPEAT:                        frame_len = 4'd1;
            default:                          frame_len = 4'd0;
        endcase
    endfunction

    assign accept    = (state_q == S_IDLE) && bus.cmd_valid_i;
    assign capture   = ((op_q == OP_STREAM) || (op_q == OP_TRANSFER)) && (idx_q != 4'd0);
    assign last_byte = (idx_q + 4'd1) >= len_q;
    assign shift_d   = capture ? {shift_q[VALUE_WIDTH-9:0], bus.spi_rx_byte_i} : shift_q;

    // Frame is built left-aligned so byte n is always the top byte after shifting by n.
    always_comb begin
        frame = '0;
        case (op_q)
            OP_WRITE:              frame = {op_q, addr_q, val_q};
            OP_READ, OP_BIND_INTERRUPT,
            OP_BIND_READ_ADDRESS,
            OP_BIND_WRITE_ADDRESS: frame = {op_q, addr_q, 32'h0};
            OP_STREAM:             frame = {op_q, val_q, 24'h0};
            OP_TRANSFER:           frame = {op_q, DUMMY_BYTE, 48'h0};
            default:               frame = {op_q, 56'h0};
        endcase
    end

    assign frame_shifted = frame << {idx_q[2:0], 3'b000};

    always_comb begin
        state_d             = state_q;
        bus.cmd_ready_o     = 1'b0;
        bus.spi_tx_valid_o  = 1'b0;
        bus.spi_tx_byte_o   = 8'h00;
        bus.resp_valid_o    = 1'b0;
        bus.err_o           = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.cmd_ready_o = 1'b1;
                if (bus.cmd_valid_i) begin
                    state_d = (frame_len(bus.cmd_instruction_i) == 4'd0) ? S_ERR : S_SEND;
                end
            end
            S_SEND: begin
                bus.spi_tx_valid_o = 1'b1;
                bus.spi_tx_byte_o  = frame_shifted[63:56];
                if (bus.spi_tx_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.spi_rx_valid_i) begin
                    state_d = last_byte ? S_DONE : S_SEND;
                end
            end
            S_DONE: begin
                bus.resp_valid_o = 1'b1;
                state_d          = S_IDLE;
            end
            S_ERR: begin
                bus.err_o = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy_o      = ~bus.cmd_ready_o;
    assign bus.resp_data_o = resp_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q    <= '0;
            addr_q  <= '0;
            val_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            resp_q  <= '0;
        end else if (accept) begin
            op_q    <= bus.cmd_instruction_i;
            addr_q  <= bus.cmd_address_i;
            val_q   <= bus.cmd_value_i;
            len_q   <= frame_len(bus.cmd_instruction_i);
            idx_q   <= '0;
            shift_q <= '0;
        end else if ((state_q == S_WAIT) && bus.spi_rx_valid_i) begin
            idx_q   <= idx_q + 4'd1;
            shift_q <= shift_d;
            if (last_byte) begin
                resp_q <= shift_d;
            end
        end
    end
endmodule
